// File: rtl/venom_pkg.sv
// Shared constants, state encoding and overlap helper for the venom hit detector.
package venom_pkg;

    localparam int unsigned COORD_W      = 10;
    localparam int unsigned SCREEN_X_MAX = 639;
    localparam int unsigned SCREEN_Y_MAX = 479;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLIGHT = 2'd1,
        HIT    = 2'd2,
        MISS   = 2'd3
    } venomState_e;

    // Absolute difference of two screen coordinates, widened so nothing is truncated.
    function automatic logic [COORD_W:0] absDiff(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
        logic signed [COORD_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        if (d < 0) d = -d;
        return d;
    endfunction

endpackage

// File: rtl/respawn_timer.sv
// Per-target alive flag: cleared on a kill, re-armed RESPAWN_FRAMES frames later.
module respawn_timer #(
    parameter int unsigned RESPAWN_FRAMES = 120
) (
    input  logic frame_clk,
    input  logic Reset,
    input  logic kill,
    output logic alive
);

    localparam int unsigned CNT_W = (RESPAWN_FRAMES > 0) ? $clog2(RESPAWN_FRAMES + 1) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            alive <= 1'b1;
            count <= '0;
        end else if (kill) begin
            alive <= 1'b0;
            count <= CNT_W'(RESPAWN_FRAMES);
        end else if (count != '0) begin
            // Alive is set on the edge that takes the counter from 1 to 0.
            if (count == CNT_W'(1)) alive <= 1'b1;
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/venom_hit_detector.sv
// Tests the venom projectile against live targets and screen bounds; holds the
// collision level for venom's flight FSM and tracks kills and score.
module venom_hit_detector
    import venom_pkg::*;
#(
    parameter int unsigned NUM_TARGETS    = 4,
    parameter int unsigned RESPAWN_FRAMES = 120,
    parameter int unsigned SCORE_W        = 10,
    parameter int unsigned HIT_POINTS     = 1
) (
    input  logic                           frame_clk,
    input  logic                           Reset,
    input  logic                           venomMovement,
    input  logic [COORD_W-1:0]             VenomX,
    input  logic [COORD_W-1:0]             VenomY,
    input  logic [COORD_W-1:0]             VenomS,
    input  logic [NUM_TARGETS*COORD_W-1:0] targetX,
    input  logic [NUM_TARGETS*COORD_W-1:0] targetY,
    input  logic [COORD_W-1:0]             targetS,
    output logic                           collision,
    output logic                           hit_pulse,
    output logic [2:0]                     hit_index,
    output logic [NUM_TARGETS-1:0]         target_alive,
    output logic [SCORE_W-1:0]             score
);

    localparam int unsigned SUM_W = COORD_W + 1;
    localparam int unsigned SCW1  = SCORE_W + 1;

    venomState_e            state;
    logic [NUM_TARGETS-1:0] overlap;
    logic [NUM_TARGETS-1:0] kill;
    logic [SUM_W-1:0]       reach;
    logic [2:0]             firstHit;
    logic                   anyHit;
    logic                   outOfBounds;
    logic                   takeHit;
    logic [SCW1-1:0]        scoreSum;
    logic [SCORE_W-1:0]     scoreNext;

    assign reach = SUM_W'(VenomS) + SUM_W'(targetS);

    // Dead targets never overlap.
    always_comb begin
        overlap = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            overlap[i] = target_alive[i]
                && (absDiff(VenomX, targetX[COORD_W*i +: COORD_W]) <= reach)
                && (absDiff(VenomY, targetY[COORD_W*i +: COORD_W]) <= reach);
        end
    end

    // Lowest overlapping index wins.
    always_comb begin
        firstHit = '0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if (overlap[i]) firstHit = 3'(i);
        end
    end

    assign anyHit = |overlap;
    // Leftward/upward wrap lands above the limits, so one compare covers both edges.
    assign outOfBounds = (VenomX > COORD_W'(SCREEN_X_MAX)) || (VenomY > COORD_W'(SCREEN_Y_MAX));
    assign takeHit = (state == FLIGHT) && venomMovement && anyHit;

    always_comb begin
        kill = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            kill[i] = takeHit && (firstHit == 3'(i));
        end
    end

    assign scoreSum  = {1'b0, score} + SCW1'(HIT_POINTS);
    assign scoreNext = scoreSum[SCORE_W] ? {SCORE_W{1'b1}} : scoreSum[SCORE_W-1:0];

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            collision <= 1'b0;
            hit_pulse <= 1'b0;
            hit_index <= '0;
            score     <= '0;
        end else begin
            hit_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    collision <= 1'b0;
                    if (venomMovement) state <= FLIGHT;
                end
                FLIGHT: begin
                    if (!venomMovement) begin
                        state     <= IDLE;
                        collision <= 1'b0;
                    end else if (anyHit) begin
                        state     <= HIT;
                        collision <= 1'b1;
                        hit_pulse <= 1'b1;
                        hit_index <= firstHit;
                        score     <= scoreNext;
                    end else if (outOfBounds) begin
                        state     <= MISS;
                        collision <= 1'b1;
                    end
                end
                HIT, MISS: begin
                    if (!venomMovement) begin
                        state     <= IDLE;
                        collision <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    collision <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_TARGETS; g++) begin : gTimer
        respawn_timer #(
            .RESPAWN_FRAMES(RESPAWN_FRAMES)
        ) uTimer (
            .frame_clk(frame_clk),
            .Reset    (Reset),
            .kill     (kill[g]),
            .alive    (target_alive[g])
        );
    end

endmodule

// File: tb/tb_venom_hit_detector.sv
// Scoreboard bench: a behavioural model predicts every frame for a default
// instance and a small one (SCORE_W=2, RESPAWN_FRAMES=3) driven in parallel.
module tb_venom_hit_detector;

    logic        frame_clk = 1'b0;
    logic        Reset = 1'b1;
    logic        venomMovement = 1'b0;
    logic [9:0]  VenomX = '0, VenomY = '0, VenomS = 10'd4, targetS = 10'd8;
    logic [39:0] targetX, targetY;

    logic       collision0, hitPulse0, collision1, hitPulse1;
    logic [2:0] hitIndex0, hitIndex1;
    logic [3:0] alive0, alive1;
    logic [9:0] score0;
    logic [1:0] score1;

    int nChecked = 0;
    int nMismatched = 0;

    always #5 frame_clk = ~frame_clk;

    venom_hit_detector uDut0 (
        .frame_clk(frame_clk), .Reset(Reset), .venomMovement(venomMovement),
        .VenomX(VenomX), .VenomY(VenomY), .VenomS(VenomS),
        .targetX(targetX), .targetY(targetY), .targetS(targetS),
        .collision(collision0), .hit_pulse(hitPulse0), .hit_index(hitIndex0),
        .target_alive(alive0), .score(score0)
    );

    venom_hit_detector #(.SCORE_W(2), .RESPAWN_FRAMES(3)) uDut1 (
        .frame_clk(frame_clk), .Reset(Reset), .venomMovement(venomMovement),
        .VenomX(VenomX), .VenomY(VenomY), .VenomS(VenomS),
        .targetX(targetX), .targetY(targetY), .targetS(targetS),
        .collision(collision1), .hit_pulse(hitPulse1), .hit_index(hitIndex1),
        .target_alive(alive1), .score(score1)
    );

    typedef struct {
        bit col;
        bit pulse;
        int idx;
        int alive;
        int score;
    } expect_t;

    expect_t sbq[$];

    int mSt[2];
    bit mAlive[2][4];
    int mCnt[2][4];
    int mScore[2];
    int mIdx[2];
    bit mCol[2];
    bit mPulse[2];

    task automatic checkEq(input string tag, input int got, input int want);
        nChecked++;
        if (got !== want) begin
            nMismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic void modelReset();
        for (int k = 0; k < 2; k++) begin
            mSt[k] = 0; mScore[k] = 0; mIdx[k] = 0; mCol[k] = 0; mPulse[k] = 0;
            for (int i = 0; i < 4; i++) begin
                mAlive[k][i] = 1'b1;
                mCnt[k][i] = 0;
            end
        end
    endfunction

    function automatic bit overlaps(input int i);
        int dx, dy, lim;
        logic [9:0] tx, ty;
        tx = targetX[10*i +: 10];
        ty = targetY[10*i +: 10];
        dx = int'(VenomX) - int'(tx);
        dy = int'(VenomY) - int'(ty);
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        lim = int'(VenomS) + int'(targetS);
        return (dx <= lim) && (dy <= lim);
    endfunction

    // Predict one frame edge for instance k and push the expected outputs.
    function automatic void modelStep(input int k);
        int hitT = -1;
        int rFrames = (k == 0) ? 120 : 3;
        int sMax = (k == 0) ? 1023 : 3;
        bit oob = (VenomX > 10'd639) || (VenomY > 10'd479);
        int aliveVec = 0;
        mPulse[k] = 1'b0;
        case (mSt[k])
            0: begin
                mCol[k] = 1'b0;
                if (venomMovement) mSt[k] = 1;
            end
            1: begin
                if (!venomMovement) begin
                    mSt[k] = 0; mCol[k] = 1'b0;
                end else begin
                    for (int i = 0; i < 4; i++)
                        if (hitT < 0 && mAlive[k][i] && overlaps(i)) hitT = i;
                    if (hitT >= 0) begin
                        mSt[k] = 2; mCol[k] = 1'b1; mPulse[k] = 1'b1; mIdx[k] = hitT;
                        mScore[k] = (mScore[k] + 1 > sMax) ? sMax : mScore[k] + 1;
                    end else if (oob) begin
                        mSt[k] = 3; mCol[k] = 1'b1;
                    end
                end
            end
            default: begin
                if (!venomMovement) begin
                    mSt[k] = 0; mCol[k] = 1'b0;
                end
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            if (i == hitT) begin
                mAlive[k][i] = 1'b0;
                mCnt[k][i] = rFrames;
            end else if (mCnt[k][i] > 0) begin
                if (mCnt[k][i] == 1) mAlive[k][i] = 1'b1;
                mCnt[k][i]--;
            end
            if (mAlive[k][i]) aliveVec |= (1 << i);
        end
        sbq.push_back('{col: mCol[k], pulse: mPulse[k], idx: mIdx[k],
                        alive: aliveVec, score: mScore[k]});
    endfunction

    task automatic compareOuts();
        expect_t w;
        for (int k = 0; k < 2; k++) begin
            if (sbq.size() == 0) begin
                checkEq("sbEmpty", 0, 1);
                return;
            end
            w = sbq.pop_front();
            checkEq($sformatf("col%0d", k),   int'(k == 0 ? collision0 : collision1), int'(w.col));
            checkEq($sformatf("pulse%0d", k), int'(k == 0 ? hitPulse0 : hitPulse1), int'(w.pulse));
            checkEq($sformatf("idx%0d", k),   int'(k == 0 ? hitIndex0 : hitIndex1), w.idx);
            checkEq($sformatf("alive%0d", k), int'(k == 0 ? alive0 : alive1), w.alive);
            checkEq($sformatf("score%0d", k), k == 0 ? int'(score0) : int'(score1), w.score);
        end
    endtask

    task automatic frame();
        modelStep(0);
        modelStep(1);
        @(posedge frame_clk);
        #1;
        compareOuts();
    endtask

    task automatic place(input logic mv, input int x, input int y);
        venomMovement = mv;
        VenomX = 10'(x);
        VenomY = 10'(y);
    endtask

    initial begin
        int hitX;
        int n;
        targetX = {10'd550, 10'd410, 10'd400, 10'd200};
        targetY = {10'd200, 10'd300, 10'd300, 10'd100};

        // Reset values
        repeat (2) @(posedge frame_clk);
        #1;
        modelReset();
        checkEq("rstCol", int'(collision0), 0);
        checkEq("rstPulse", int'(hitPulse0), 0);
        checkEq("rstIdx", int'(hitIndex0), 0);
        checkEq("rstAlive", int'(alive0), 15);
        checkEq("rstScore", int'(score0), 0);
        checkEq("rstAlive1", int'(alive1), 15);
        Reset = 1'b0;

        // Shot rightward onto target 0
        hitX = -1;
        for (int k = 0; k < 40; k++) begin
            place(1'b1, 101 + 3 * k, 100);
            frame();
            if (hitX < 0 && collision0) hitX = int'(VenomX);
        end
        checkEq("hitAtX", hitX, 188);
        checkEq("hit1Idx", int'(hitIndex0), 0);
        checkEq("hit1Alive", int'(alive0), 4'b1110);
        checkEq("hit1Score", int'(score0), 1);
        place(1'b0, 230, 100);
        frame();
        checkEq("hit1Drop", int'(collision0), 0);

        // Leftward shot wraps past zero
        place(1'b1, 5, 240); frame();
        place(1'b1, 2, 240); frame();
        checkEq("preWrapCol", int'(collision0), 0);
        place(1'b1, -1, 240); frame();
        checkEq("wrapCol", int'(collision0), 1);
        place(1'b1, -4, 240); frame();
        checkEq("wrapScore", int'(score0), 1);
        checkEq("wrapAlive", int'(alive0), 4'b1110);
        place(1'b0, -7, 240); frame();
        checkEq("wrapDrop", int'(collision0), 0);

        // Two overlapping targets: lowest index wins
        place(1'b1, 300, 300); frame();
        place(1'b1, 405, 300); frame();
        checkEq("dualIdx", int'(hitIndex0), 1);
        checkEq("dualAlive", int'(alive0), 4'b1100);
        checkEq("dualScore", int'(score0), 2);
        place(1'b0, 405, 300); frame();

        // Hit and out-of-bounds together: hit wins
        targetY[29:20] = 10'd496;
        place(1'b1, 300, 300); frame();
        place(1'b1, 410, 500); frame();
        checkEq("hitOobIdx", int'(hitIndex0), 2);
        checkEq("hitOobPulse", int'(hitPulse0), 1);
        checkEq("hitOobScore", int'(score0), 3);
        place(1'b0, 410, 500); frame();
        targetY[29:20] = 10'd300;

        // Kill target 3, shoot through it while dead, count respawn frames
        place(1'b1, 300, 200); frame();
        place(1'b1, 550, 200); frame();
        checkEq("kill3Idx", int'(hitIndex0), 3);
        checkEq("kill3Dead", int'(alive0[3]), 0);
        n = 0;
        place(1'b0, 550, 200); frame(); n++;
        for (int k = 0; k < 4; k++) begin
            place(1'b1, 550, 200); frame(); n++;
            checkEq("deadTgtCol", int'(collision0), 0);
        end
        place(1'b0, 550, 200);
        while (!alive0[3] && n < 200) begin
            frame(); n++;
        end
        checkEq("respawnFrames", n, 120);

        // Repeated kills saturate the 2-bit score
        for (int j = 0; j < 4; j++) begin
            place(1'b1, 300, 100); frame();
            place(1'b1, 200, 100); frame();
            place(1'b0, 200, 100);
            repeat (5) frame();
        end
        checkEq("scoreSat", int'(score1), 3);

        // Asynchronous reset mid-flight
        place(1'b1, 300, 50); frame();
        place(1'b1, 303, 50); frame();
        #2;
        Reset = 1'b1;
        #1;
        modelReset();
        checkEq("midRstCol", int'(collision0), 0);
        checkEq("midRstScore", int'(score0), 0);
        checkEq("midRstAlive", int'(alive0), 15);
        checkEq("midRstScore1", int'(score1), 0);
        #1;
        Reset = 1'b0;
        place(1'b1, 200, 100); frame();
        checkEq("idleAfterRst", int'(collision0), 0);
        frame();
        checkEq("hitAfterRst", int'(collision0), 1);
        place(1'b0, 200, 100); frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecked, nMismatched);
        $finish;
    end

endmodule
